// File: rtl/cache_port_arbiter.sv
// Two-port arbiter sharing one blocking cache between I-side (p0) and D-side (p1).
// Ports: p0_*/p1_* requesters, cache_* to cache, acc_cnt/miss_cnt perf counters.
module cache_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wr_data,
  output logic              p0_req_ready,
  output logic              p0_resp_valid,
  output logic [DATA_W-1:0] p0_rd_data,
  input  logic              p1_req_valid,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wr_data,
  output logic              p1_req_ready,
  output logic              p1_resp_valid,
  output logic [DATA_W-1:0] p1_rd_data,
  input  logic              cache_miss,
  input  logic [DATA_W-1:0] cache_rd_data,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_rd_req,
  output logic              cache_wr_req,
  output logic [DATA_W-1:0] cache_wr_data,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic state;
  logic last_grant;
  logic owner;
  logic miss_seen;
  logic any_req;
  logic win;

  assign any_req = p0_req_valid | p1_req_valid;

  // p1 wins when alone, or on a round-robin tie when p0 went last
  assign win = p1_req_valid
             & (~p0_req_valid
                | ((FIXED_PRIO == 0) & ~last_grant));

  assign p0_req_ready = (state == ST_IDLE)
                      & p0_req_valid & ~win;
  assign p1_req_ready = (state == ST_IDLE) & win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      miss_seen     <= 1'b0;
      cache_addr    <= '0;
      cache_wr_data <= '0;
      cache_rd_req  <= 1'b0;
      cache_wr_req  <= 1'b0;
      p0_resp_valid <= 1'b0;
      p1_resp_valid <= 1'b0;
      p0_rd_data    <= '0;
      p1_rd_data    <= '0;
      acc_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      p0_resp_valid <= 1'b0;
      p1_resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            cache_addr    <= win ? p1_addr : p0_addr;
            cache_wr_data <= win ? p1_wr_data
                                 : p0_wr_data;
            cache_rd_req  <= win ? ~p1_req_we
                                 : ~p0_req_we;
            cache_wr_req  <= win ? p1_req_we
                                 : p0_req_we;
            owner         <= win;
            last_grant    <= win;
            miss_seen     <= 1'b0;
            state         <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cache_miss) begin
            miss_seen <= 1'b1;
          end else begin
            cache_rd_req <= 1'b0;
            cache_wr_req <= 1'b0;
            state        <= ST_IDLE;
            if (owner) begin
              p1_resp_valid <= 1'b1;
              p1_rd_data    <= cache_rd_req
                             ? cache_rd_data : '0;
            end else begin
              p0_resp_valid <= 1'b1;
              p0_rd_data    <= cache_rd_req
                             ? cache_rd_data : '0;
            end
            if (acc_cnt != CNT_MAX)
              acc_cnt <= acc_cnt + CNT_W'(1);
            if (miss_seen && miss_cnt != CNT_MAX)
              miss_cnt <= miss_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: a round-robin instance with
// 2-bit counters and a fixed-priority instance share all inputs.
module tb_cache_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req_valid, p0_req_we;
  logic [31:0] p0_addr, p0_wr_data;
  logic        p1_req_valid, p1_req_we;
  logic [31:0] p1_addr, p1_wr_data;
  logic        cache_miss;
  logic [31:0] cache_rd_data;
  logic [31:0] rd_xor;

  logic        rr_p0_ready, rr_p0_rv, rr_p1_ready, rr_p1_rv;
  logic [31:0] rr_p0_rd, rr_p1_rd, rr_addr, rr_wd;
  logic        rr_rd_req, rr_wr_req;
  logic [1:0]  rr_acc, rr_miss;

  logic        fp_p0_ready, fp_p0_rv, fp_p1_ready, fp_p1_rv;
  logic [31:0] fp_p0_rd, fp_p1_rd, fp_addr, fp_wd;
  logic        fp_rd_req, fp_wr_req;
  logic [31:0] fp_acc, fp_miss;

  logic [31:0] mem [64];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_port_arbiter #(.CNT_W(2), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we),
    .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
    .p0_req_ready(rr_p0_ready), .p0_resp_valid(rr_p0_rv),
    .p0_rd_data(rr_p0_rd),
    .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we),
    .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
    .p1_req_ready(rr_p1_ready), .p1_resp_valid(rr_p1_rv),
    .p1_rd_data(rr_p1_rd),
    .cache_miss(cache_miss), .cache_rd_data(cache_rd_data),
    .cache_addr(rr_addr), .cache_rd_req(rr_rd_req),
    .cache_wr_req(rr_wr_req), .cache_wr_data(rr_wd),
    .acc_cnt(rr_acc), .miss_cnt(rr_miss)
  );

  cache_port_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we),
    .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
    .p0_req_ready(fp_p0_ready), .p0_resp_valid(fp_p0_rv),
    .p0_rd_data(fp_p0_rd),
    .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we),
    .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
    .p1_req_ready(fp_p1_ready), .p1_resp_valid(fp_p1_rv),
    .p1_rd_data(fp_p1_rd),
    .cache_miss(cache_miss), .cache_rd_data(cache_rd_data),
    .cache_addr(fp_addr), .cache_rd_req(fp_rd_req),
    .cache_wr_req(fp_wr_req), .cache_wr_data(fp_wd),
    .acc_cnt(fp_acc), .miss_cnt(fp_miss)
  );

  // tiny cache model following the round-robin instance
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (rr_wr_req && !cache_miss) begin
      mem[rr_addr[7:2]] <= rr_wd;
    end
  end
  assign cache_rd_data = mem[rr_addr[7:2]] ^ rd_xor;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    p0_req_valid = 0; p0_req_we = 0; p0_addr = 0; p0_wr_data = 0;
    p1_req_valid = 0; p1_req_we = 0; p1_addr = 0; p1_wr_data = 0;
    cache_miss = 0; rd_xor = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({rr_rd_req, rr_wr_req, rr_p0_rv, rr_p1_rv} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctl got %b req 0",
        {rr_rd_req, rr_wr_req, rr_p0_rv, rr_p1_rv});
    end
    n_cmp++;
    if ({rr_addr, rr_wd, rr_p0_rd, rr_p1_rd, rr_acc, rr_miss} !== '0) begin
      n_err++; $display("FAIL reset_data got %h %h %h %h %h %h req 0",
        rr_addr, rr_wd, rr_p0_rd, rr_p1_rd, rr_acc, rr_miss);
    end
    // first tie after reset goes to p0
    p0_req_valid = 1; p1_req_valid = 1;
    #1;
    n_cmp++;
    if ({rr_p0_ready, rr_p1_ready} !== 2'b10) begin
      n_err++; $display("FAIL reset_first_tie got %b req 10",
        {rr_p0_ready, rr_p1_ready});
    end
    do_reset();
  endtask

  task automatic test_single_port();
    do_reset();
    p0_req_valid = 1; p0_req_we = 1; p0_addr = 32'h10; p0_wr_data = 32'h3d;
    #1;
    n_cmp++;
    if ({rr_p0_ready, rr_p1_ready} !== 2'b10) begin
      n_err++; $display("FAIL wr_accept got %b req 10",
        {rr_p0_ready, rr_p1_ready});
    end
    tick();
    p0_req_valid = 0;
    n_cmp++;
    if ({rr_wr_req, rr_rd_req, rr_addr, rr_wd, rr_p0_ready}
        !== {1'b1, 1'b0, 32'h10, 32'h3d, 1'b0}) begin
      n_err++; $display("FAIL wr_issue got %b %b %h %h req 1 0 10 3d",
        rr_wr_req, rr_rd_req, rr_addr, rr_wd);
    end
    tick();
    n_cmp++;
    if ({rr_p0_rv, rr_p1_rv, rr_p0_rd, rr_wr_req}
        !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_err++; $display("FAIL wr_resp got %b %b %h %b req 1 0 0 0",
        rr_p0_rv, rr_p1_rv, rr_p0_rd, rr_wr_req);
    end
    p0_req_valid = 1; p0_req_we = 0; p0_addr = 32'h10; p0_wr_data = 32'h0;
    #1;
    n_cmp++;
    if (rr_p0_ready !== 1'b1) begin
      n_err++; $display("FAIL rd_accept got %b req 1", rr_p0_ready);
    end
    tick();
    p0_req_valid = 0;
    n_cmp++;
    if ({rr_rd_req, rr_wr_req, rr_p0_rv} !== 3'b100) begin
      n_err++; $display("FAIL rd_issue got %b req 100",
        {rr_rd_req, rr_wr_req, rr_p0_rv});
    end
    tick();
    n_cmp++;
    if ({rr_p0_rv, rr_p0_rd, rr_acc, rr_miss}
        !== {1'b1, 32'h3d, 2'd2, 2'd0}) begin
      n_err++; $display("FAIL rd_resp got %b %h acc %0d miss %0d req 1 3d 2 0",
        rr_p0_rv, rr_p0_rd, rr_acc, rr_miss);
    end
    tick();
    n_cmp++;
    if ({rr_p0_rv, rr_p0_rd} !== {1'b0, 32'h3d}) begin
      n_err++; $display("FAIL rd_hold got %b %h req 0 3d", rr_p0_rv, rr_p0_rd);
    end
  endtask

  task automatic test_miss_stall();
    do_reset();
    rd_xor = 32'ha5a5_0024;
    p1_req_valid = 1; p1_req_we = 0; p1_addr = 32'h24; cache_miss = 1;
    #1;
    n_cmp++;
    if ({rr_p0_ready, rr_p1_ready} !== 2'b01) begin
      n_err++; $display("FAIL stall_accept got %b req 01",
        {rr_p0_ready, rr_p1_ready});
    end
    tick();
    p1_req_valid = 0; p1_addr = 32'h88;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({rr_addr, rr_rd_req, rr_wr_req, rr_p0_rv, rr_p1_rv}
          !== {32'h24, 4'b1000}) begin
        n_err++; $display("FAIL stall_hold[%0d] got %h %b req 24 1000", i,
          rr_addr, {rr_rd_req, rr_wr_req, rr_p0_rv, rr_p1_rv});
      end
      tick();
    end
    cache_miss = 0;
    tick();
    n_cmp++;
    if ({rr_p1_rv, rr_p0_rv, rr_p1_rd, rr_p0_rd, rr_acc, rr_miss}
        !== {2'b10, 32'ha5a5_0024, 32'h0, 2'd1, 2'd1}) begin
      n_err++; $display("FAIL stall_resp got %b%b %h %h %0d %0d req 10 a5a50024 0 1 1",
        rr_p1_rv, rr_p0_rv, rr_p1_rd, rr_p0_rd, rr_acc, rr_miss);
    end
    tick();
    n_cmp++;
    if ({rr_p1_rv, rr_rd_req} !== 2'b00) begin
      n_err++; $display("FAIL stall_once got %b req 00", {rr_p1_rv, rr_rd_req});
    end
    rd_xor = 0;
  endtask

  task automatic test_round_robin();
    logic exp_g;
    do_reset();
    p0_req_valid = 1; p0_addr = 32'h100;
    p1_req_valid = 1; p1_addr = 32'h200;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2) == 1;
      n_cmp++;
      if ({rr_p0_ready, rr_p1_ready} !== {~exp_g, exp_g}) begin
        n_err++; $display("FAIL rr_grant[%0d] got %b req %b", k,
          {rr_p0_ready, rr_p1_ready}, {~exp_g, exp_g});
      end
      tick();
      n_cmp++;
      if ({rr_addr, rr_p0_ready, rr_p1_ready}
          !== {(exp_g ? 32'h200 : 32'h100), 2'b00}) begin
        n_err++; $display("FAIL rr_busy[%0d] got %h %b", k,
          rr_addr, {rr_p0_ready, rr_p1_ready});
      end
      tick();
      n_cmp++;
      if ({rr_p0_rv, rr_p1_rv} !== {~exp_g, exp_g}) begin
        n_err++; $display("FAIL rr_resp[%0d] got %b req %b", k,
          {rr_p0_rv, rr_p1_rv}, {~exp_g, exp_g});
      end
    end
    p0_req_valid = 0; p1_req_valid = 0;
    n_cmp++;
    if (rr_acc !== 2'd3) begin
      n_err++; $display("FAIL rr_acc_sat got %0d req 3", rr_acc);
    end
    tick();
  endtask

  task automatic test_fixed_prio();
    do_reset();
    p0_req_valid = 1; p0_addr = 32'h300;
    p1_req_valid = 1; p1_addr = 32'h400;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({fp_p0_ready, fp_p1_ready} !== 2'b10) begin
        n_err++; $display("FAIL fp_grant[%0d] got %b req 10", k,
          {fp_p0_ready, fp_p1_ready});
      end
      tick();
      tick();
      n_cmp++;
      if ({fp_p0_rv, fp_p1_rv} !== 2'b10) begin
        n_err++; $display("FAIL fp_resp[%0d] got %b req 10", k,
          {fp_p0_rv, fp_p1_rv});
      end
    end
    p0_req_valid = 0;
    #1;
    n_cmp++;
    if ({fp_p0_ready, fp_p1_ready} !== 2'b01) begin
      n_err++; $display("FAIL fp_p1_grant got %b req 01",
        {fp_p0_ready, fp_p1_ready});
    end
    tick();
    p1_req_valid = 0;
    n_cmp++;
    if (fp_addr !== 32'h400) begin
      n_err++; $display("FAIL fp_p1_addr got %h req 400", fp_addr);
    end
    tick();
    n_cmp++;
    if ({fp_p1_rv, fp_p0_rv, fp_acc} !== {2'b10, 32'd4}) begin
      n_err++; $display("FAIL fp_p1_resp got %b acc %0d req 10 4",
        {fp_p1_rv, fp_p0_rv}, fp_acc);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    p0_req_valid = 1; p0_req_we = 1; p0_addr = 32'h40; p0_wr_data = 32'h77;
    tick();
    p0_req_valid = 0;
    tick();
    p0_req_valid = 1; p0_addr = 32'h44; cache_miss = 1;
    tick();
    p0_req_valid = 0;
    tick();
    n_cmp++;
    if ({rr_wr_req, rr_acc} !== {1'b1, 2'd1}) begin
      n_err++; $display("FAIL mid_pre got %b acc %0d req 1 1", rr_wr_req, rr_acc);
    end
    rst = 1;
    tick();
    rst = 0;
    n_cmp++;
    if ({rr_rd_req, rr_wr_req, rr_p0_rv, rr_p1_rv, rr_acc, rr_miss}
        !== 8'b0) begin
      n_err++; $display("FAIL mid_reset got %b %0d %0d req 0",
        {rr_rd_req, rr_wr_req, rr_p0_rv, rr_p1_rv}, rr_acc, rr_miss);
    end
    cache_miss = 0;
    tick();
    n_cmp++;
    if ({rr_p0_rv, rr_p1_rv} !== 2'b00) begin
      n_err++; $display("FAIL mid_no_resp got %b req 00", {rr_p0_rv, rr_p1_rv});
    end
    p1_req_valid = 1; p1_req_we = 0; p1_addr = 32'h48;
    #1;
    n_cmp++;
    if (rr_p1_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_after_accept got %b req 1", rr_p1_ready);
    end
    tick();
    p1_req_valid = 0;
    tick();
    n_cmp++;
    if ({rr_p1_rv, rr_acc} !== {1'b1, 2'd1}) begin
      n_err++; $display("FAIL mid_after_resp got %b acc %0d req 1 1",
        rr_p1_rv, rr_acc);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    p0_req_we = 0; p0_addr = 32'h8;
    for (int k = 0; k < 5; k++) begin
      p0_req_valid = 1;
      tick();
      p0_req_valid = 0;
      tick();
      n_cmp++;
      if ({rr_p0_rv, rr_acc, rr_miss}
          !== {1'b1, ((k < 3) ? 2'(k + 1) : 2'd3), 2'd0}) begin
        n_err++; $display("FAIL sat[%0d] got rv %b acc %0d miss %0d", k,
          rr_p0_rv, rr_acc, rr_miss);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_miss_stall();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid_op();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Two-requester arbiter that shares the single-ported blocking `cache` (miss/rd_req/wr_req interface) between an instruction-side port (port 0) and a data-side port (port 1).
- Accepts one request at a time, drives it to the cache and holds it stable until the cache drops `miss`.
- Returns a registered response to the owning port and keeps saturating access/miss performance counters.
- Sits between the CPU pipeline front/back ends and the cache instance.

Parameters:
- ADDR_W, 32, address width on both requester ports and the cache port.
- DATA_W, 32, data word width.
- CNT_W, 32, width of the performance counters.
- FIXED_PRIO, 0, arbitration mode: 0 = round-robin, 1 = port 0 always wins ties.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- p0_req_valid  in  1  port 0 request present; held until accepted
- p0_req_we  in  1  port 0: 1 = write, 0 = read
- p0_addr  in  ADDR_W  port 0 byte address
- p0_wr_data  in  DATA_W  port 0 write data
- p0_req_ready  out  1  port 0 request accepted this cycle (combinational)
- p0_resp_valid  out  1  one-cycle pulse: port 0 request completed
- p0_rd_data  out  DATA_W  port 0 read data, valid with p0_resp_valid on reads
- p1_req_valid, p1_req_we, p1_addr, p1_wr_data, p1_req_ready, p1_resp_valid, p1_rd_data  same as port 0, for port 1
- cache_miss  in  1  cache `miss`; high = current request not yet complete
- cache_rd_data  in  DATA_W  cache `rd_data`; valid in the cycle cache_rd_req=1 and cache_miss=0
- cache_addr  out  ADDR_W  registered address to cache
- cache_rd_req  out  1  registered read request
- cache_wr_req  out  1  registered write request
- cache_wr_data  out  DATA_W  registered write data
- acc_cnt  out  CNT_W  completed accesses, saturating
- miss_cnt  out  CNT_W  completed accesses that saw cache_miss=1 for at least one cycle, saturating

Behaviour:
- Reset (synchronous): state=IDLE; cache_rd_req, cache_wr_req, cache_addr, cache_wr_data = 0; p*_resp_valid = 0; p*_rd_data = 0; acc_cnt = miss_cnt = 0; last_grant = 1, so port 0 wins the first tie; owner = 0; miss_seen = 0.
- Reset mid-transaction abandons the request without a response; the cache shares rst.
- States: IDLE, BUSY.
- IDLE:
  - If any p*_req_valid, select a winner:
    - only one valid → that port;
    - both valid, FIXED_PRIO=1 → port 0;
    - both valid, FIXED_PRIO=0 → the port != last_grant.
  - pN_req_ready=1 combinationally for the winner only. The loser's ready is 0 and it must hold its request.
  - At the accepting edge:
    - latch addr and wr_data into cache_addr/cache_wr_data;
    - cache_rd_req = ~we, cache_wr_req = we;
    - owner = N, last_grant = N, miss_seen = 0;
    - state → BUSY.
- BUSY:
  - p*_req_ready = 0; cache_* outputs held constant.
  - cache_miss=1: miss_seen ← 1; stay BUSY.
  - cache_miss=0 (completion):
    - clear cache_rd_req/wr_req; state → IDLE;
    - p[owner]_resp_valid = 1 for exactly the next cycle;
    - on a read, p[owner]_rd_data ← cache_rd_data; on a write, p[owner]_rd_data ← 0;
    - acc_cnt += 1; miss_cnt += 1 if miss_seen;
    - each counter saturates at 2^CNT_W-1.
- Latency:
  - accept in cycle t → cache request asserted t+1;
  - on a hit (cache_miss=0 in t+1), resp_valid is asserted in t+2;
  - the next accept can occur no earlier than t+2 (one IDLE cycle after each completion).
- The non-owner's resp_valid stays 0. p*_rd_data holds its value between responses.
- p*_req_valid changing while not accepted has no effect. Requester inputs are ignored in BUSY.
- Only one outstanding cache request at any time, so write-then-read to the same address by different ports is ordered by grant order.

Test Plan:
- Single port write/read hit:
  - p0 writes addr 0x10 data 0x3d, then reads 0x10.
  - Expect p0_req_ready in the accept cycle, cache_wr_req in the following cycle, then p0_resp_valid, then a read response with p0_rd_data=0x3d.
  - acc_cnt=2 after both complete.
- Miss stall:
  - hold cache_miss=1 for 5 cycles on a p1 read of 0x24.
  - Expect cache_addr=0x24 and cache_rd_req stable for all 5 cycles, no resp_valid during the stall, p1_resp_valid exactly once afterwards, miss_cnt=1.
- Round-robin:
  - both ports valid continuously for 4 transactions with FIXED_PRIO=0 from reset.
  - Expect grant order 0,1,0,1 and the loser's req_ready=0 in each accept cycle.
- Fixed priority:
  - FIXED_PRIO=1, both valid for 3 transactions.
  - Expect grants 0,0,0 while p1 stays unacknowledged; grant goes to 1 once p0_req_valid drops.
- Reset mid-operation:
  - assert rst while BUSY with cache_miss=1.
  - Expect cache_rd_req=cache_wr_req=0, no resp_valid and counters=0 after the reset edge; the next request is accepted normally.
- Counter saturation:
  - CNT_W=2, run 5 hits.
  - Expect acc_cnt to stick at 3.
